// File: rtl/rv32i_pkg.sv
// Shared rv32i package: memory access size and LSU state encodings, plus a
// helper that decides whether an access violates its natural alignment.
package rv32i_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_DONE  = 2'd3
  } lsu_state_e;

  // The reserved size encoding (2'b11) is rejected like a misaligned access
  // so it can never reach the PSRAM.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lsb);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = lsb[0];
      MEM_WORD: is_misaligned = |lsb;
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering between the 32-bit core data path
// and the 16-bit PSRAM data path.
//   size, addr_b0, beat, wdata -> wr_data, wr_high, wr_low (store lanes/strobes)
//   size, addr_b0, is_unsigned, rd_lo, rd_hi -> rd_data (extended load value)
module lsu_align
  import rv32i_pkg::*;
(
  input  mem_size_e   size,
  input  logic        addr_b0,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic        is_unsigned,
  input  logic [15:0] rd_lo,
  input  logic [15:0] rd_hi,
  output logic [15:0] wr_data,
  output logic        wr_high,
  output logic        wr_low,
  output logic [31:0] rd_data
);

  logic [7:0] byte_sel;

  assign byte_sel = addr_b0 ? rd_lo[15:8] : rd_lo[7:0];

  // Store side: a byte is replicated on both lanes and the strobe picks the
  // lane; a word sends its low half on beat 0 and its high half on beat 1.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    wr_data = wdata[15:0];
    wr_high = 1'b1;
    wr_low  = 1'b1;
    case (size)
      MEM_BYTE: begin
        wr_data = {wdata[7:0], wdata[7:0]};
        wr_high = addr_b0;
        wr_low  = ~addr_b0;
      end
      MEM_WORD: wr_data = beat ? wdata[31:16] : wdata[15:0];
      default:  ;
    endcase
  end

  // Load side: extract the addressed lane and sign/zero-extend.
  always_comb begin
    rd_data = '0;
    case (size)
      MEM_BYTE: rd_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      MEM_HALF: rd_data = {{16{~is_unsigned & rd_lo[15]}}, rd_lo};
      MEM_WORD: rd_data = {rd_hi, rd_lo};
      default:  ;
    endcase
  end

endmodule

// File: rtl/psram_lsu.sv
// psram_lsu: single-outstanding load/store unit bridging a 32-bit core
// memory port to 16-bit PSRAM banks. Word accesses are split into two
// 16-bit beats (low half first).
//   Core side : req_valid/we/addr/size/unsigned/wdata in; stall, rsp_valid,
//               rsp_rdata, rsp_err out.
//   PSRAM side: ps_bank_sel, ps_addr, ps_data_in, byte strobes,
//               ps_write_en/ps_read_en out; ps_data_out, ps_read_avail,
//               ps_busy in.
module psram_lsu
  import rv32i_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int NUM_BANKS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  req_valid,
  input  logic                                  req_we,
  input  logic [31:0]                           req_addr,
  input  mem_size_e                             req_size,
  input  logic                                  req_unsigned,
  input  logic [31:0]                           req_wdata,
  output logic                                  stall,
  output logic                                  rsp_valid,
  output logic [31:0]                           rsp_rdata,
  output logic                                  rsp_err,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] ps_bank_sel,
  output logic [ADDR_W-1:0]                     ps_addr,
  output logic [15:0]                           ps_data_in,
  output logic                                  ps_write_high_byte,
  output logic                                  ps_write_low_byte,
  output logic                                  ps_write_en,
  output logic                                  ps_read_en,
  input  logic [15:0]                           ps_data_out,
  input  logic                                  ps_read_avail,
  input  logic                                  ps_busy
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state;
  logic              beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic [BANK_W-1:0] bank_q;
  logic              addr_b0_q;
  logic [31:0]       wdata_q;
  mem_size_e         size_q;
  logic              we_q;
  logic              unsigned_q;
  logic              err_q;
  logic [15:0]       lo_q;
  logic [15:0]       hi_q;

  logic [BANK_W-1:0] req_bank;
  logic              issue_fire;
  logic              beat_done;
  logic [15:0]       wr_data;
  logic              wr_high;
  logic              wr_low;
  logic [31:0]       ld_data;

  generate
    if (NUM_BANKS > 1) begin : g_bank
      assign req_bank = req_addr[ADDR_W+1 +: BANK_W];
    end else begin : g_single
      assign req_bank = 1'b0;
    end
  endgenerate

  lsu_align u_align (
    .size        (size_q),
    .addr_b0     (addr_b0_q),
    .beat        (beat_q),
    .wdata       (wdata_q),
    .is_unsigned (unsigned_q),
    .rd_lo       (lo_q),
    .rd_hi       (hi_q),
    .wr_data     (wr_data),
    .wr_high     (wr_high),
    .wr_low      (wr_low),
    .rd_data     (ld_data)
  );

  // The strobe fires in the single ISSUE cycle where the PSRAM is free; the
  // FSM leaves ISSUE on that same edge, so the pulse is exactly one cycle.
  assign issue_fire = (state == LSU_ISSUE) && !ps_busy;
  assign ps_read_en  = issue_fire && !we_q;
  assign ps_write_en = issue_fire && we_q;
  assign ps_write_high_byte = ps_write_en && wr_high;
  assign ps_write_low_byte  = ps_write_en && wr_low;
  assign ps_data_in  = wr_data;
  assign ps_bank_sel = bank_q;
  // Second beat of a word wraps inside the bank's word address space.
  assign ps_addr     = word_addr_q + ADDR_W'(beat_q);

  // A store beat is accepted once the PSRAM drops busy; WAIT is always at
  // least one cycle after the issue pulse.
  assign beat_done = we_q ? !ps_busy : ps_read_avail;

  assign stall     = ((state == LSU_IDLE) && req_valid) ||
                     (state == LSU_ISSUE) || (state == LSU_WAIT);
  assign rsp_valid = (state == LSU_DONE);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld_data : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LSU_IDLE;
      beat_q      <= 1'b0;
      cnt_q       <= '0;
      word_addr_q <= '0;
      bank_q      <= '0;
      addr_b0_q   <= 1'b0;
      wdata_q     <= '0;
      size_q      <= MEM_BYTE;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      err_q       <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            word_addr_q <= req_addr[ADDR_W:1];
            bank_q      <= req_bank;
            addr_b0_q   <= req_addr[0];
            wdata_q     <= req_wdata;
            size_q      <= req_size;
            we_q        <= req_we;
            unsigned_q  <= req_unsigned;
            beat_q      <= 1'b0;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= LSU_DONE;
            end else begin
              err_q <= 1'b0;
              state <= LSU_ISSUE;
            end
          end
        end
        LSU_ISSUE: begin
          if (!ps_busy) begin
            cnt_q <= '0;
            state <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (beat_done) begin
            if (!we_q) begin
              if (beat_q) hi_q <= ps_data_out;
              else        lo_q <= ps_data_out;
            end
            if ((size_q == MEM_WORD) && !beat_q) begin
              beat_q <= 1'b1;
              state  <= LSU_ISSUE;
            end else begin
              state <= LSU_DONE;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Timeout abandons any remaining beats; rsp_rdata is masked by err.
            err_q <= 1'b1;
            state <= LSU_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LSU_DONE: begin
          beat_q <= 1'b0;
          state  <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_lsu.sv
// Directed testbench for psram_lsu with a small PSRAM responder.
module tb_psram_lsu;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  mem_size_e   req_size;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [0:0]  ps_bank_sel;
  logic [21:0] ps_addr;
  logic [15:0] ps_data_in, ps_data_out;
  logic        ps_write_high_byte, ps_write_low_byte, ps_write_en, ps_read_en;
  logic        ps_read_avail, ps_busy;

  psram_lsu #(.ADDR_W(22), .NUM_BANKS(2), .TIMEOUT(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_we             (req_we),
    .req_addr           (req_addr),
    .req_size           (req_size),
    .req_unsigned       (req_unsigned),
    .req_wdata          (req_wdata),
    .stall              (stall),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .ps_bank_sel        (ps_bank_sel),
    .ps_addr            (ps_addr),
    .ps_data_in         (ps_data_in),
    .ps_write_high_byte (ps_write_high_byte),
    .ps_write_low_byte  (ps_write_low_byte),
    .ps_write_en        (ps_write_en),
    .ps_read_en         (ps_read_en),
    .ps_data_out        (ps_data_out),
    .ps_read_avail      (ps_read_avail),
    .ps_busy            (ps_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0      = 0;

  // Pulse log for the current request.
  int          n_pulse, n_rd, n_wr, both_cnt, rsp_cnt;
  logic [31:0] p_addr [8];
  logic [15:0] p_data [8];
  logic        p_hi [8], p_lo [8], p_bank [8];
  int          p_cyc [8];
  logic [31:0] r_data;
  logic        r_err, r_stall;
  int          r_cyc;

  // Responder state.
  logic [15:0] rd_beat [2];
  int          rd_idx;
  logic        rd_seen = 1'b0;
  logic        rd_respond = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ps_read_en && ps_write_en) both_cnt++;
    if (ps_read_en) begin n_rd++; rd_seen = 1'b1; end
    if (ps_write_en) n_wr++;
    if ((ps_read_en || ps_write_en) && n_pulse < 8) begin
      p_addr[n_pulse] = 32'(ps_addr);
      p_data[n_pulse] = ps_data_in;
      p_hi[n_pulse]   = ps_write_high_byte;
      p_lo[n_pulse]   = ps_write_low_byte;
      p_bank[n_pulse] = ps_bank_sel[0];
      p_cyc[n_pulse]  = cyc;
      n_pulse++;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      r_data  = rsp_rdata;
      r_err   = rsp_err;
      r_cyc   = cyc;
      r_stall = stall;
    end
  end

  // Returns read data one cycle after a read pulse (i.e. in the first WAIT cycle).
  always @(posedge clk) begin
    #1;
    ps_read_avail = 1'b0;
    if (rd_seen) begin
      rd_seen = 1'b0;
      if (rd_respond) begin
        ps_read_avail = 1'b1;
        ps_data_out   = rd_beat[rd_idx % 2];
        rd_idx++;
      end
    end
  end

  task automatic clear_log();
    n_pulse = 0; n_rd = 0; n_wr = 0; rsp_cnt = 0; rd_idx = 0;
    r_data = '0; r_err = 1'b0; r_stall = 1'b1; r_cyc = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_req(input logic we, input logic [31:0] addr, input mem_size_e size,
                        input logic uns, input logic [31:0] wdata, input int busy_cycles);
    clear_log();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    c0 = cyc;
    if (busy_cycles > 0) begin
      ps_busy = 1'b1;
      repeat (busy_cycles + 1) @(posedge clk);
      #1 ps_busy = 1'b0;
    end
    for (int i = 0; i < 40 && rsp_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    if (rsp_cnt == 0) check("rsp_arrival", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = MEM_BYTE; req_unsigned = 1'b0; req_wdata = '0;
    ps_data_out = '0; ps_read_avail = 1'b0; ps_busy = 1'b0;
    both_cnt = 0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes", 32'(ps_read_en | ps_write_en | ps_write_high_byte | ps_write_low_byte), 32'd0);
    check("rst_ps_addr", 32'(ps_addr), 32'd0);
    check("rst_rsp", {rsp_rdata[31:1], rsp_err}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Word store split into two beats.
    do_req(1'b1, 32'h0000_0010, MEM_WORD, 1'b0, 32'hDEAD_BEEF, 0);
    check("ws_nwr", 32'(n_wr), 32'd2);
    check("ws_nrd", 32'(n_rd), 32'd0);
    check("ws_addr0", p_addr[0], 32'h8);
    check("ws_data0", 32'(p_data[0]), 32'hBEEF);
    check("ws_addr1", p_addr[1], 32'h9);
    check("ws_data1", 32'(p_data[1]), 32'hDEAD);
    check("ws_strb", {28'd0, p_hi[0], p_lo[0], p_hi[1], p_lo[1]}, 32'hF);
    check("ws_issue_lat", 32'(p_cyc[0] - c0), 32'd1);
    check("ws_done_lat", 32'(r_cyc - c0), 32'd5);
    check("ws_nrsp", 32'(rsp_cnt), 32'd1);
    check("ws_stall_done", 32'(r_stall), 32'd0);
    check("ws_rsp", {r_data[31:1], r_err}, 32'd0);

    // Byte loads from the high lane, signed then unsigned.
    rd_beat[0] = 16'h80AA;
    do_req(1'b0, 32'h0000_0003, MEM_BYTE, 1'b0, 32'h0, 0);
    check("lb_addr", p_addr[0], 32'h1);
    check("lb_signed", r_data, 32'hFFFF_FF80);
    do_req(1'b0, 32'h0000_0003, MEM_BYTE, 1'b1, 32'h0, 0);
    check("lbu_unsigned", r_data, 32'h0000_0080);
    rd_beat[0] = 16'h1234;
    do_req(1'b0, 32'h0000_0002, MEM_BYTE, 1'b0, 32'h0, 0);
    check("lb_low_lane", r_data, 32'h0000_0034);

    // Byte stores: lane selection by addr[0], data replicated.
    do_req(1'b1, 32'h0000_0004, MEM_BYTE, 1'b0, 32'h1234_565A, 0);
    check("sb_lo_data", 32'(p_data[0]), 32'h5A5A);
    check("sb_lo_strb", {30'd0, p_hi[0], p_lo[0]}, 32'h1);
    do_req(1'b1, 32'h0000_0005, MEM_BYTE, 1'b0, 32'h1234_56C3, 0);
    check("sb_hi_strb", {30'd0, p_hi[0], p_lo[0]}, 32'h2);
    check("sb_hi_addr", p_addr[0], 32'h2);

    // Half loads, signed and unsigned.
    rd_beat[0] = 16'h8001;
    do_req(1'b0, 32'h0000_0002, MEM_HALF, 1'b0, 32'h0, 0);
    check("lh_signed", r_data, 32'hFFFF_8001);
    do_req(1'b0, 32'h0000_0002, MEM_HALF, 1'b1, 32'h0, 0);
    check("lhu_unsigned", r_data, 32'h0000_8001);

    // Word load assembled from two beats.
    rd_beat[0] = 16'h5678; rd_beat[1] = 16'h1234;
    do_req(1'b0, 32'h0000_0008, MEM_WORD, 1'b0, 32'h0, 0);
    check("lw_data", r_data, 32'h1234_5678);
    check("lw_addrs", {p_addr[0][15:0], p_addr[1][15:0]}, 32'h0004_0005);
    check("lw_nrd", 32'(n_rd), 32'd2);

    // Misaligned accesses: error in the cycle after the request, no PSRAM access.
    do_req(1'b0, 32'h0000_0001, MEM_HALF, 1'b0, 32'h0, 0);
    check("mis_h_err", 32'(r_err), 32'd1);
    check("mis_h_lat", 32'(r_cyc - c0), 32'd1);
    check("mis_h_nrd", 32'(n_rd), 32'd0);
    check("mis_h_data", r_data, 32'd0);
    do_req(1'b1, 32'h0000_0012, MEM_WORD, 1'b0, 32'hFFFF_FFFF, 0);
    check("mis_w_err", 32'(r_err), 32'd1);
    check("mis_w_nwr", 32'(n_wr), 32'd0);

    // Bank bit set plus PSRAM busy for 5 cycles delays the issue by 5.
    rd_beat[0] = 16'hBEEF;
    do_req(1'b0, 32'h0080_0004, MEM_HALF, 1'b1, 32'h0, 5);
    check("bank_sel", 32'(p_bank[0]), 32'd1);
    check("bank_addr", p_addr[0], 32'h2);
    check("busy_issue_lat", 32'(p_cyc[0] - c0), 32'd6);
    check("bank_data", r_data, 32'h0000_BEEF);

    // Read never answered: timeout error, single read pulse.
    rd_respond = 1'b0;
    do_req(1'b0, 32'h0000_0020, MEM_WORD, 1'b0, 32'h0, 0);
    check("to_err", 32'(r_err), 32'd1);
    check("to_data", r_data, 32'd0);
    check("to_nrd", 32'(n_rd), 32'd1);

    // Reset asserted while waiting on the first beat of a word load.
    @(posedge clk); #1;
    clear_log();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
    req_size = MEM_WORD; req_unsigned = 1'b0;
    #1 check("idle_req_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 20 && n_rd == 0; i++) begin
      @(posedge clk); #1;
    end
    check("rstw_first_pulse", 32'(n_rd), 32'd1);
    reset_n = 1'b0; req_valid = 1'b0;
    #1;
    check("rstw_stall", 32'(stall), 32'd0);
    check("rstw_outs", 32'(rsp_valid | ps_read_en | ps_write_en), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1; rd_respond = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rstw_no_beat2", 32'(n_rd), 32'd1);
    check("rstw_no_rsp", 32'(rsp_cnt), 32'd0);

    check("rd_wr_exclusive", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_lsu.md
PSRAM_LSU -- requirements
Module: psram_lsu

Interface
REQ-001 Parameter ADDR_W, default 22, word (16-bit) address width per PSRAM bank.
REQ-002 Parameter NUM_BANKS, default 2, number of PSRAM banks; SHALL be a power of two, at least 1.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent waiting on one PSRAM beat.
REQ-004 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-005 req_valid  in  1  core memory request, held stable while stall=1.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_addr  in  32  byte address; bank = req_addr[ADDR_W+1 +: log2(NUM_BANKS)].
REQ-008 req_size  in  2  mem_size_e: BYTE, HALF, WORD.
REQ-009 req_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 stall  out  1  core must hold pc and request.
REQ-012 rsp_valid  out  1  one-cycle completion strobe; rsp_rdata  out  32  extended load data; rsp_err  out  1  misaligned or timeout.
REQ-013 ps_bank_sel  out  max(1,log2(NUM_BANKS)); ps_addr  out  ADDR_W; ps_data_in  out  16; ps_write_high_byte, ps_write_low_byte, ps_write_en, ps_read_en  out  1 each.
REQ-014 ps_data_out  in  16; ps_read_avail  in  1; ps_busy  in  1.

Function
REQ-015 States IDLE, ISSUE, WAIT, DONE; one request in flight; no queueing.
REQ-016 stall SHALL equal (state==IDLE && req_valid) || state==ISSUE || state==WAIT; stall=0 in DONE.
REQ-017 IDLE + req_valid: latch address, wdata, size, we, unsigned; go to DONE with rsp_err=1 if misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0), else go to ISSUE, beat=0.
REQ-018 Beats: BYTE and HALF take 1 beat; WORD takes 2 beats, low half at word address addr[ADDR_W:1], high half at that +1 (wraps modulo 2^ADDR_W within the bank).
REQ-019 ISSUE: while ps_busy=1 hold; when ps_busy=0 pulse ps_read_en or ps_write_en for exactly one cycle, go to WAIT, clear timeout counter.
REQ-020 Byte strobes: BYTE addr[0]=0 -> low only, addr[0]=1 -> high only, data byte replicated on both lanes; HALF and WORD beats -> both strobes.
REQ-021 WAIT: load beat completes on ps_read_avail=1 (capture ps_data_out); store beat completes on first cycle with ps_busy=0 at least one cycle after issue.
REQ-022 On beat completion: if more beats remain, beat+1 and return to ISSUE; else go to DONE.
REQ-023 WAIT counter reaching TIMEOUT without completion: go to DONE with rsp_err=1, rsp_rdata=0, remaining beats abandoned.
REQ-024 DONE: rsp_valid=1 for one cycle, then IDLE; req_valid in DONE is ignored (new request only in IDLE).
REQ-025 Load result: BYTE selects lane by addr[0]; HALF uses the captured 16 bits; WORD = {high beat, low beat}; extended per req_unsigned; stores return rsp_rdata=0.
REQ-026 ps_read_en and ps_write_en never both 1; both 0 outside ISSUE.
REQ-027 rsp_err=1 forces rsp_rdata=0; no PSRAM access occurs for misaligned requests.

Reset
REQ-028 reset_n=0 at any time: state=IDLE, beat=0, counter=0, all outputs 0 (stall follows REQ-016 from IDLE), in-flight beat abandoned without further pulse.

Structure
REQ-029 mem_size_e and lsu_state_e SHALL live in the shared rv32i package.
REQ-030 Combinational sub-module lsu_align SHALL hold store lane placement/strobes and load extraction/extension.

Verification
REQ-031 WORD store 0xDEADBEEF to 0x0000_0010 -> beats at ps_addr 0x8 data 0xBEEF, 0x9 data 0xDEAD, both strobes, one rsp_valid, stall low in DONE.
REQ-032 BYTE load addr 0x3, ps_data_out 0x80xx, req_unsigned=0 -> rsp_rdata 0xFFFFFF80; req_unsigned=1 -> 0x00000080.
REQ-033 HALF load addr 0x1 -> rsp_err=1 in cycle 2, no ps_read_en pulse.
REQ-034 Address with bank bit set (NUM_BANKS=2, addr bit 23=1) -> ps_bank_sel=1; ps_busy held 1 for 5 cycles -> issue delayed exactly 5 cycles.
REQ-035 WORD load with ps_read_avail never asserted, TIMEOUT=4 -> rsp_err=1, rsp_rdata=0, exactly one read pulse.
REQ-036 reset_n low during WAIT of a WORD load -> IDLE next edge-free instant, no second beat, no rsp_valid.
